// File: rtl/perceptron_trainer_pkg.sv
// Shared definitions for the perceptron trainer: FSM state encoding and the
// class-count derivation used by the interface, the top and the argmax block.
package perceptron_trainer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCORE,
    DECIDE,
    UPDATE,
    DONE
  } state_t;

  // Number of classes addressed by a class index of c_width bits.
  function automatic int classes_of(input int c_width);
    return 1 << c_width;
  endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// Sample / preload / result bundle of the perceptron trainer.
// master = sample source and observer, slave = trainer.
interface perceptron_trainer_if #(
  parameter int WIDTH    = 8,
  parameter int FEATURES = 2,
  parameter int C_WIDTH  = 1
);
  import perceptron_trainer_pkg::*;

  localparam int CLASSES = classes_of(C_WIDTH);

  logic                                in_valid;
  logic                                in_ready;
  logic [FEATURES*WIDTH-1:0]           features;
  logic [C_WIDTH-1:0]                  label;
  logic                                ld_en;
  logic [CLASSES*FEATURES*WIDTH-1:0]   ld_weights;
  logic [CLASSES*FEATURES*WIDTH-1:0]   weights;
  logic                                out_valid;
  logic [C_WIDTH-1:0]                  out_class;
  logic [WIDTH-1:0]                    out_value;
  logic                                mispredict;

  modport master (
    output in_valid, features, label, ld_en, ld_weights,
    input  in_ready, weights, out_valid, out_class, out_value, mispredict
  );

  modport slave (
    input  in_valid, features, label, ld_en, ld_weights,
    output in_ready, weights, out_valid, out_class, out_value, mispredict
  );

endinterface

// File: rtl/perceptron_argmax.sv
// Combinational argmax over CLASSES packed unsigned scores.
// Strict greater-than while scanning upward keeps the lowest index on ties.
module perceptron_argmax
  import perceptron_trainer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int C_WIDTH = 1
) (
  input  logic [classes_of(C_WIDTH)*WIDTH-1:0] scores,
  output logic [C_WIDTH-1:0]                   best_idx,
  output logic [WIDTH-1:0]                     best_val
);

  localparam int CLASSES = classes_of(C_WIDTH);

  // Scan classes in ascending order, replacing only on a strictly larger score.
  always_comb begin
    best_idx = '0;
    best_val = scores[0 +: WIDTH];
    for (int i = 1; i < CLASSES; i++) begin
      if (scores[i*WIDTH +: WIDTH] > best_val) begin
        best_idx = C_WIDTH'(i);
        best_val = scores[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Multi-class perceptron trainer: scores one sample with one MAC per cycle,
// picks the best class, and on a mispredict moves the true-class weights
// toward the sample and the predicted-class weights away from it.
// Optional macro PERCEPTRON_TRAINER_SAT_EN: weight updates saturate to
// [0, 2**WIDTH-1] instead of wrapping. Scoring always wraps.
module perceptron_trainer
  import perceptron_trainer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int FEATURES = 2,
  parameter int C_WIDTH  = 1
) (
  input logic                clk,
  input logic                rst,
  perceptron_trainer_if.slave bus
);

  localparam int CLASSES = classes_of(C_WIDTH);
  localparam int N       = CLASSES * FEATURES;
  localparam int AW      = (N > 1) ? $clog2(N) : 1;
  localparam int FW      = (FEATURES > 1) ? $clog2(FEATURES) : 1;

  state_t             state_reg;
  logic [C_WIDTH-1:0] cls_reg;
  logic [FW-1:0]      feat_reg;
  logic [C_WIDTH-1:0] label_reg;
  logic [C_WIDTH-1:0] pred_reg;
  logic [WIDTH-1:0]   pred_val_reg;
  logic [WIDTH-1:0]   x_reg      [FEATURES];
  logic [WIDTH-1:0]   w_reg      [N];
  logic [WIDTH-1:0]   scores_reg [CLASSES];
  logic               out_valid_reg;
  logic [C_WIDTH-1:0] out_class_reg;
  logic [WIDTH-1:0]   out_value_reg;
  logic               mispredict_reg;

  logic [AW-1:0]              score_addr;
  logic [AW-1:0]              lbl_addr;
  logic [AW-1:0]              pred_addr;
  logic [WIDTH-1:0]           prod;
  logic [CLASSES*WIDTH-1:0]   scores_flat;
  logic [C_WIDTH-1:0]         best_idx;
  logic [WIDTH-1:0]           best_val;

  // Weight (c,f) lives at c*FEATURES+f, matching the external packing.
  assign score_addr = AW'(cls_reg) * AW'(FEATURES) + AW'(feat_reg);
  assign lbl_addr   = AW'(label_reg) * AW'(FEATURES) + AW'(feat_reg);
  assign pred_addr  = AW'(pred_reg) * AW'(FEATURES) + AW'(feat_reg);
  assign prod       = w_reg[score_addr] * x_reg[feat_reg];

  generate
    for (genvar gi = 0; gi < CLASSES; gi++) begin : g_scores
      assign scores_flat[gi*WIDTH +: WIDTH] = scores_reg[gi];
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_weights
      assign bus.weights[gi*WIDTH +: WIDTH] = w_reg[gi];
    end
  endgenerate

  perceptron_argmax #(
    .WIDTH   (WIDTH),
    .C_WIDTH (C_WIDTH)
  ) u_argmax (
    .scores   (scores_flat),
    .best_idx (best_idx),
    .best_val (best_val)
  );

  assign bus.in_ready   = (state_reg == IDLE) && !bus.ld_en;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_class  = out_class_reg;
  assign bus.out_value  = out_value_reg;
  assign bus.mispredict = mispredict_reg;

  function automatic logic [WIDTH-1:0] w_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
`ifdef PERCEPTRON_TRAINER_SAT_EN
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? '1 : s[WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] w_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
`ifdef PERCEPTRON_TRAINER_SAT_EN
    return (b > a) ? '0 : a - b;
`else
    return a - b;
`endif
  endfunction

  // Trainer FSM plus weight store, score accumulators and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cls_reg        <= '0;
      feat_reg       <= '0;
      label_reg      <= '0;
      pred_reg       <= '0;
      pred_val_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_class_reg  <= '0;
      out_value_reg  <= '0;
      mispredict_reg <= 1'b0;
      for (int i = 0; i < N; i++)        w_reg[i]      <= '0;
      for (int i = 0; i < CLASSES; i++)  scores_reg[i] <= '0;
      for (int i = 0; i < FEATURES; i++) x_reg[i]      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.ld_en) begin
            for (int i = 0; i < N; i++)
              w_reg[i] <= bus.ld_weights[i*WIDTH +: WIDTH];
          end else if (bus.in_valid) begin
            for (int i = 0; i < FEATURES; i++)
              x_reg[i] <= bus.features[i*WIDTH +: WIDTH];
            label_reg <= bus.label;
            cls_reg   <= '0;
            feat_reg  <= '0;
            state_reg <= SCORE;
          end
        end
        SCORE: begin
          // First feature of a class restarts its accumulator.
          scores_reg[cls_reg] <= (feat_reg == '0) ? prod : scores_reg[cls_reg] + prod;
          if (feat_reg == FW'(FEATURES - 1)) begin
            feat_reg <= '0;
            if (cls_reg == {C_WIDTH{1'b1}}) state_reg <= DECIDE;
            else                            cls_reg   <= cls_reg + 1'b1;
          end else begin
            feat_reg <= feat_reg + 1'b1;
          end
        end
        DECIDE: begin
          pred_reg     <= best_idx;
          pred_val_reg <= best_val;
          feat_reg     <= '0;
          if (best_idx != label_reg) begin
            state_reg <= UPDATE;
          end else begin
            out_valid_reg  <= 1'b1;
            out_class_reg  <= best_idx;
            out_value_reg  <= best_val;
            mispredict_reg <= 1'b0;
            state_reg      <= DONE;
          end
        end
        UPDATE: begin
          // label != pred here, so the two writes never hit the same entry.
          w_reg[lbl_addr]  <= w_add(w_reg[lbl_addr], x_reg[feat_reg]);
          w_reg[pred_addr] <= w_sub(w_reg[pred_addr], x_reg[feat_reg]);
          if (feat_reg == FW'(FEATURES - 1)) begin
            out_valid_reg  <= 1'b1;
            out_class_reg  <= pred_reg;
            out_value_reg  <= pred_val_reg;
            mispredict_reg <= 1'b1;
            state_reg      <= DONE;
          end else begin
            feat_reg <= feat_reg + 1'b1;
          end
        end
        DONE: begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer (WIDTH=8, FEATURES=2, C_WIDTH=1).
// Honours PERCEPTRON_TRAINER_SAT_EN in its reference model.
module tb_perceptron_trainer;
  import perceptron_trainer_pkg::*;

  localparam int W  = 8;
  localparam int F  = 2;
  localparam int CW = 1;
  localparam int C  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  perceptron_trainer_if #(.WIDTH(W), .FEATURES(F), .C_WIDTH(CW)) bus ();

  perceptron_trainer #(.WIDTH(W), .FEATURES(F), .C_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int m_w [C][F];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int upd(input int v);
`ifdef PERCEPTRON_TRAINER_SAT_EN
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
`else
    return v & 255;
`endif
  endfunction

  task automatic check_weights(input string tag);
    for (int c = 0; c < C; c++)
      for (int f = 0; f < F; f++)
        check($sformatf("%s_w%0d%0d", tag, c, f), bus.weights[(c*F+f)*W +: W], m_w[c][f]);
  endtask

  task automatic clear_model();
    for (int c = 0; c < C; c++)
      for (int f = 0; f < F; f++)
        m_w[c][f] = 0;
  endtask

  // Entered and left on a falling edge.
  task automatic preload(input logic [31:0] pk);
    bus.ld_en      = 1'b1;
    bus.ld_weights = pk;
    for (int c = 0; c < C; c++)
      for (int f = 0; f < F; f++)
        m_w[c][f] = int'(pk[(c*F+f)*W +: W]);
    #1 check("ld_in_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.ld_en = 1'b0;
    check_weights("ld");
    $display("preload pk=%08h", pk);
  endtask

  // One training sample; glitch pulses ld_en mid-SCORE, abort resets in UPDATE.
  task automatic run_sample(input int x0, input int x1, input int lbl,
                            input bit glitch, input bit abort);
    int s [C];
    int xs [F];
    int pred, lat, exp_lat;
    bit mis, seen;
    logic [7:0] xa, xb;
    logic [CW-1:0] lb;
    xs[0] = x0; xs[1] = x1;
    for (int c = 0; c < C; c++) begin
      s[c] = 0;
      for (int f = 0; f < F; f++) s[c] += m_w[c][f] * xs[f];
      s[c] = s[c] % 256;
    end
    pred = 0;
    for (int c = 1; c < C; c++) if (s[c] > s[pred]) pred = c;
    mis     = (pred != lbl);
    exp_lat = mis ? 8 : 6;

    xa = x0[7:0]; xb = x1[7:0]; lb = lbl[CW-1:0];
    bus.features = {xb, xa};
    bus.label    = lb;
    bus.in_valid = 1'b1;
    #1 check("accept_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;

    lat = 0; seen = 0;
    while (lat < 40 && !seen) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_ready", bus.in_ready, 0);
      if (glitch && lat == 2) begin bus.ld_en = 1'b1; bus.ld_weights = $urandom; end
      if (glitch && lat == 3) bus.ld_en = 1'b0;
      if (abort && lat == 6) rst = 1'b1;
      if (abort && lat == 7) rst = 1'b0;
      if (bus.out_valid === 1'b1) seen = 1;
    end

    if (abort) begin
      check("abort_no_valid", 32'(seen), 0);
      clear_model();
      check_weights("abort");
      check("abort_ready", bus.in_ready, 1);
      $display("sample x=(%0d,%0d) label=%0d aborted in UPDATE", x0, x1, lbl);
    end else begin
      check("valid_seen", 32'(seen), 1);
      check("latency", lat, exp_lat);
      check("out_class", bus.out_class, pred);
      check("out_value", bus.out_value, s[pred]);
      check("mispredict", bus.mispredict, 32'(mis));
      if (mis) begin
        for (int f = 0; f < F; f++) begin
          m_w[lbl][f]  = upd(m_w[lbl][f] + xs[f]);
          m_w[pred][f] = upd(m_w[pred][f] - xs[f]);
        end
      end
      check_weights("upd");
      @(negedge clk);
      check("valid_pulse", bus.out_valid, 0);
      check("class_hold", bus.out_class, pred);
      check("idle_ready", bus.in_ready, 1);
      $display("sample x=(%0d,%0d) label=%0d pred=%0d value=%0d mis=%0d lat=%0d",
               x0, x1, lbl, pred, s[pred], mis, lat);
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.features   = '0;
    bus.label      = '0;
    bus.ld_en      = 1'b0;
    bus.ld_weights = '0;
    rst            = 1'b1;
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_weights("reset");
    check("reset_ready", bus.in_ready, 1);
    check("reset_valid", bus.out_valid, 0);
    check("reset_class", bus.out_class, 0);
    check("reset_value", bus.out_value, 0);
    check("reset_mis", bus.mispredict, 0);
    $display("reset done");

    // Tie on zero weights: class 0 wins, mispredict, update.
    run_sample(3, 4, 1, 0, 0);
`ifdef PERCEPTRON_TRAINER_SAT_EN
    check("tie_w00", bus.weights[7:0], 0);
    check("tie_w01", bus.weights[15:8], 0);
`else
    check("tie_w00", bus.weights[7:0], 253);
    check("tie_w01", bus.weights[15:8], 252);
`endif
    check("tie_w10", bus.weights[23:16], 3);
    check("tie_w11", bus.weights[31:24], 4);

    // Correct prediction, no update.
    preload({8'd2, 8'd2, 8'd1, 8'd1});
    run_sample(10, 20, 1, 0, 0);

    // Score wraps: class 1 becomes 144 < 200.
    preload({8'd0, 8'd200, 8'd0, 8'd100});
    run_sample(2, 0, 0, 0, 0);
    check("wrap_class", bus.out_class, 0);
    check("wrap_value", bus.out_value, 200);

    // ld_en during SCORE is ignored.
    run_sample($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), 1, 0);

    // Reset mid-UPDATE aborts the sample.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    run_sample(3, 4, 1, 0, 1);

    // Randomized training.
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) preload($urandom);
      run_sample($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
